// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multicycle MIPS control path.
// Opcode constants, main-controller state encoding, ALUOp encodings (also
// consumed by the ALU control unit), ALUSrcB / PCSource mux encodings, and
// the control-vector struct produced by the output decoder.
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       pcwrite;
        logic       pcwritecond;
        logic       illegal;
        logic       retire;
    } ctrl_t;

    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_cu_outdec.sv
// mips_cu_outdec: combinational state -> control-vector decode.
//   state     in   current controller state
//   mem_ready in   memory handshake (only looked at in FETCH / MEMWR)
//   opcode    in   IR opcode (only looked at in DECODE, for illegal)
//   ctrl      out  full datapath control vector incl. illegal / retire
module mips_cu_outdec
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.memread  = 1'b1;
                ctrl.alusrcb  = SRCB_FOUR;
                ctrl.aluop    = ALUOP_ADD;
                ctrl.pcsource = PCSRC_ALU;
                // IR and PC+4 commit only when the fetch read completes
                ctrl.irwrite  = mem_ready;
                ctrl.pcwrite  = mem_ready;
            end
            S_DECODE: begin
                // speculative branch target: PC + (imm << 2)
                ctrl.alusrcb  = SRCB_IMMSH;
                ctrl.aluop    = ALUOP_ADD;
                ctrl.illegal  = ~is_known_op(opcode);
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca  = 1'b1;
                ctrl.alusrcb  = SRCB_IMM;
                ctrl.aluop    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.memread  = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.retire   = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.retire   = mem_ready;
            end
            S_EXEC: begin
                ctrl.alusrca  = 1'b1;
                ctrl.alusrcb  = SRCB_B;
                ctrl.aluop    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
                ctrl.retire   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca     = 1'b1;
                ctrl.alusrcb     = SRCB_B;
                ctrl.aluop       = ALUOP_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsource    = PCSRC_ALUOUT;
                ctrl.retire      = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsource = PCSRC_JUMP;
                ctrl.retire   = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.retire   = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_main_cu.sv
// mips_main_cu: multicycle MIPS main control unit.
//   clk, rst          clock / async active-high reset
//   opcode            IR[31:26], valid from DECODE on
//   mem_ready         memory completes the current access this cycle
//   IorD..PCWriteCond datapath enables and mux selects
//   illegal           one-cycle pulse in DECODE for an unknown opcode
//   retire            one-cycle pulse in the last cycle of an instruction
//   retire_count      wrapping count of retired instructions
module mips_main_cu
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] retire_count
);

    state_t state, state_nxt;
    ctrl_t  ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:         state_nxt = S_EXEC;
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_nxt = S_FETCH;
            S_EXEC:   state_nxt = S_ALUWB;
            S_ADDIEX: state_nxt = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: state_nxt = S_FETCH;
            default:  state_nxt = S_FETCH;
        endcase
    end

    mips_cu_outdec u_outdec (
        .state     (state),
        .mem_ready (mem_ready),
        .opcode    (opcode),
        .ctrl      (ctrl)
    );

    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.memread;
    assign MemWrite    = ctrl.memwrite;
    assign IRWrite     = ctrl.irwrite;
    assign RegDst      = ctrl.regdst;
    assign MemtoReg    = ctrl.memtoreg;
    assign RegWrite    = ctrl.regwrite;
    assign ALUSrcA     = ctrl.alusrca;
    assign ALUSrcB     = ctrl.alusrcb;
    assign ALUOp       = ctrl.aluop;
    assign PCSource    = ctrl.pcsource;
    assign PCWrite     = ctrl.pcwrite;
    assign PCWriteCond = ctrl.pcwritecond;
    assign illegal     = ctrl.illegal;
    assign retire      = ctrl.retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         retire_count <= '0;
        else if (retire) retire_count <= retire_count + 1'b1;
    end

endmodule

// File: tb/tb_mips_main_cu.sv
// tb_mips_main_cu: directed-vector bench for mips_main_cu (CNT_W=4 so the
// counter wrap is reachable). Each cycle applies opcode/mem_ready and compares
// the whole control vector against a hand-written expected word.
module tb_mips_main_cu;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [5:0]       opcode = 6'd0;
    logic             mem_ready = 1'b0;
    logic             IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg;
    logic             RegWrite, ALUSrcA, PCWrite, PCWriteCond, illegal, retire;
    logic [1:0]       ALUSrcB, ALUOp, PCSource;
    logic [CNT_W-1:0] retire_count;

    int vectors = 0;
    int miscompares = 0;

    mips_main_cu #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .illegal(illegal), .retire(retire), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    // {IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
    //  ALUSrcB[2],ALUOp[2],PCSource[2],PCWrite,PCWriteCond,illegal,retire}
    logic [17:0] ctl;
    assign ctl = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                  ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, PCWriteCond,
                  illegal, retire};

    localparam logic [17:0] V_FETCH0  = 18'b0_1_0_0_0_0_0_0_01_00_00_0_0_0_0;
    localparam logic [17:0] V_FETCH1  = 18'b0_1_0_1_0_0_0_0_01_00_00_1_0_0_0;
    localparam logic [17:0] V_DECODE  = 18'b0_0_0_0_0_0_0_0_11_00_00_0_0_0_0;
    localparam logic [17:0] V_DECILL  = 18'b0_0_0_0_0_0_0_0_11_00_00_0_0_1_0;
    localparam logic [17:0] V_MEMADR  = 18'b0_0_0_0_0_0_0_1_10_00_00_0_0_0_0;
    localparam logic [17:0] V_MEMRD   = 18'b1_1_0_0_0_0_0_0_00_00_00_0_0_0_0;
    localparam logic [17:0] V_MEMWB   = 18'b0_0_0_0_0_1_1_0_00_00_00_0_0_0_1;
    localparam logic [17:0] V_MEMWR0  = 18'b1_0_1_0_0_0_0_0_00_00_00_0_0_0_0;
    localparam logic [17:0] V_MEMWR1  = 18'b1_0_1_0_0_0_0_0_00_00_00_0_0_0_1;
    localparam logic [17:0] V_EXEC    = 18'b0_0_0_0_0_0_0_1_00_10_00_0_0_0_0;
    localparam logic [17:0] V_ALUWB   = 18'b0_0_0_0_1_0_1_0_00_00_00_0_0_0_1;
    localparam logic [17:0] V_BRANCH  = 18'b0_0_0_0_0_0_0_1_00_01_01_0_1_0_1;
    localparam logic [17:0] V_JUMP    = 18'b0_0_0_0_0_0_0_0_00_00_10_1_0_0_1;
    localparam logic [17:0] V_ADDIWB  = 18'b0_0_0_0_0_0_1_0_00_00_00_0_0_0_1;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    // one controller cycle: drive inputs, compare control vector, advance
    task automatic cyc(input string tag, input logic [5:0] op, input logic mr,
                       input logic [17:0] exp);
        opcode = op;
        mem_ready = mr;
        #1;
        chk(tag, {14'd0, ctl}, {14'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_ctl", {14'd0, ctl}, {14'd0, V_FETCH0});
        chk("rst_cnt", 32'(retire_count), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // R-type
        cyc("r_fetch",  R, 1'b1, V_FETCH1);
        cyc("r_decode", R, 1'b1, V_DECODE);
        cyc("r_exec",   R, 1'b1, V_EXEC);
        cyc("r_aluwb",  R, 1'b1, V_ALUWB);
        chk("r_cnt", 32'(retire_count), 32'd1);

        // lw with two wait cycles in MEMRD: 7 cycles
        cyc("lw_fetch",  LW, 1'b1, V_FETCH1);
        cyc("lw_decode", LW, 1'b1, V_DECODE);
        cyc("lw_memadr", LW, 1'b1, V_MEMADR);
        cyc("lw_memrd0", LW, 1'b0, V_MEMRD);
        cyc("lw_memrd1", LW, 1'b0, V_MEMRD);
        cyc("lw_memrd2", LW, 1'b1, V_MEMRD);
        cyc("lw_memwb",  LW, 1'b1, V_MEMWB);
        chk("lw_cnt", 32'(retire_count), 32'd2);

        // beq then j
        cyc("beq_fetch",  BEQ, 1'b1, V_FETCH1);
        cyc("beq_decode", BEQ, 1'b1, V_DECODE);
        cyc("beq_branch", BEQ, 1'b1, V_BRANCH);
        cyc("j_fetch",    J,   1'b1, V_FETCH1);
        cyc("j_decode",   J,   1'b1, V_DECODE);
        cyc("j_jump",     J,   1'b1, V_JUMP);
        chk("bj_cnt", 32'(retire_count), 32'd4);

        // illegal opcode: pulse in DECODE, straight back to FETCH, no retire
        cyc("ill_fetch",  6'h3f, 1'b1, V_FETCH1);
        cyc("ill_decode", 6'h3f, 1'b1, V_DECILL);
        cyc("ill_next",   6'h3f, 1'b0, V_FETCH0);
        chk("ill_cnt", 32'(retire_count), 32'd4);

        // addi; mem_ready low in DECODE/ADDIEX must not matter
        cyc("addi_fetch",  ADDI, 1'b1, V_FETCH1);
        cyc("addi_decode", ADDI, 1'b0, V_DECODE);
        cyc("addi_ex",     ADDI, 1'b0, V_MEMADR);
        cyc("addi_wb",     ADDI, 1'b1, V_ADDIWB);
        chk("addi_cnt", 32'(retire_count), 32'd5);

        // sw with one wait cycle
        cyc("sw_fetch",  SW, 1'b1, V_FETCH1);
        cyc("sw_decode", SW, 1'b1, V_DECODE);
        cyc("sw_memadr", SW, 1'b1, V_MEMADR);
        cyc("sw_memwr0", SW, 1'b0, V_MEMWR0);
        cyc("sw_memwr1", SW, 1'b1, V_MEMWR1);
        chk("sw_cnt", 32'(retire_count), 32'd6);

        // sw interrupted by reset mid-MEMWR
        cyc("swr_fetch",  SW, 1'b1, V_FETCH1);
        cyc("swr_decode", SW, 1'b1, V_DECODE);
        cyc("swr_memadr", SW, 1'b1, V_MEMADR);
        mem_ready = 1'b0;
        #1;
        chk("swr_memwr", 32'(MemWrite), 32'd1);
        rst = 1'b1;
        #1;
        chk("swr_rst_ctl", {14'd0, ctl}, {14'd0, V_FETCH0});
        chk("swr_rst_cnt", 32'(retire_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc("swr_resume", J, 1'b0, V_FETCH0);

        // 15 jumps to reach max count, then one more wraps
        for (int i = 0; i < 15; i++) begin
            cyc("wj_fetch", J, 1'b1, V_FETCH1);
            cyc("wj_decode", J, 1'b1, V_DECODE);
            cyc("wj_jump", J, 1'b1, V_JUMP);
        end
        chk("wrap_max", 32'(retire_count), 32'd15);
        cyc("wj_fetch", J, 1'b1, V_FETCH1);
        cyc("wj_decode", J, 1'b1, V_DECODE);
        cyc("wj_jump", J, 1'b1, V_JUMP);
        chk("wrap_zero", 32'(retire_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
